// File: rtl/grf_pkg.sv
// Shared types and constants for the GRF write-port arbiter and its secondary writeback FIFO.
package grf_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [REG_W-1:0] r);
    return 32'd1 << r;
  endfunction
endpackage

// File: rtl/grf_wb_fifo.sv
// DEPTH-entry synchronous FIFO of secondary writebacks; exposes per-slot valid bits and contents
// so the owner can build a pending-register mask. Caller must not push when full or pop when empty.
module grf_wb_fifo
  import grf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      vld,
  output wb_entry_t [DEPTH-1:0] entries
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [DEPTH-1:0]      vld_q;
  logic [DEPTH-1:0]      vld_n;

  // Push and pop never hit the same slot: that would need the FIFO to be both full and non-full.
  always_comb begin
    vld_n = vld_q;
    if (pop)  vld_n[rd_ptr_q] = 1'b0;
    if (push) vld_n[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      vld_q <= vld_n;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign full    = &vld_q;
  assign empty   = ~|vld_q;
  assign head    = mem_q[rd_ptr_q];
  assign vld     = vld_q;
  assign entries = mem_q;
endmodule

// File: rtl/grf_wport_arb.sv
// GRF write-port arbiter: W stage has fixed priority, secondary writes queue and drain in W-idle cycles.
// Define GRF_WB_BYPASS_EN to let a secondary write go straight to the port when W is idle and the queue is empty.
module grf_wport_arb
  import grf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [REG_W-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              grf_we,
  output logic [REG_W-1:0]  grf_wa,
  output logic [DATA_W-1:0] grf_wd,
  output logic [31:0]       pend_mask,
  output logic              stall_req,
  output logic              waw_err
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  logic                  w_act;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  starve_hit;
  logic [CW-1:0]         starve_cnt;
  wb_entry_t             head;
  wb_entry_t             b_entry;
  logic [DEPTH-1:0]      vld;
  wb_entry_t [DEPTH-1:0] entries;

  // A write to $0 is a no-op, so such a W cycle counts as idle.
  assign w_act   = w_we && (w_addr != REG_ZERO);
  assign b_ready = !reset && !full;

`ifdef GRF_WB_BYPASS_EN
  assign bypass = !reset && !w_act && empty && b_valid && (b_addr != REG_ZERO);
`else
  assign bypass = 1'b0;
`endif

  assign push         = b_valid && b_ready && (b_addr != REG_ZERO) && !bypass;
  assign pop          = !reset && !w_act && !empty;
  assign b_entry.addr = b_addr;
  assign b_entry.data = b_data;

  grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (b_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .vld        (vld),
    .entries    (entries)
  );

  always_comb begin
    grf_we = 1'b0;
    grf_wa = '0;
    grf_wd = '0;
    if (!reset) begin
      if (w_act) begin
        grf_we = 1'b1;
        grf_wa = w_addr;
        grf_wd = w_data;
      end else if (!empty) begin
        grf_we = 1'b1;
        grf_wa = head.addr;
        grf_wd = head.data;
      end else if (bypass) begin
        grf_we = 1'b1;
        grf_wa = b_addr;
        grf_wd = b_data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pend_mask = pend_mask | reg_onehot(entries[i].addr);
    end
  end

  // Counter saturates at its last value; stall_req is sticky until the head finally drains.
  assign starve_hit = w_act && !empty && (starve_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      waw_err    <= 1'b0;
    end else begin
      waw_err <= w_act && pend_mask[w_addr];
      if (pop || empty)              starve_cnt <= '0;
      else if (w_act && !starve_hit) starve_cnt <= starve_cnt + 1'b1;
      if (pop)             stall_req <= 1'b0;
      else if (starve_hit) stall_req <= 1'b1;
    end
  end
endmodule

// File: tb/tb_grf_wport_arb.sv
// Bench for grf_wport_arb: directed vector table, hand sequences for queue/starvation corners, random traffic vs a queue model.
module tb_grf_wport_arb;
  import grf_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] pend_mask;
  logic        stall_req;
  logic        waw_err;

  always #5 clk = ~clk;

  grf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .grf_we    (grf_we),
    .grf_wa    (grf_wa),
    .grf_wd    (grf_wd),
    .pend_mask (pend_mask),
    .stall_req (stall_req),
    .waw_err   (waw_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue of outstanding secondary writes plus a streak counter of blocked cycles.
  wb_entry_t   mq[$];
  int          m_streak = 0;
  logic        m_stall  = 1'b0;
  logic        m_waw    = 1'b0;
  logic        e_wact, e_ready, e_bypass, e_we;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_mask;

  task automatic model_comb();
    e_wact  = w_we && (w_addr != 5'd0);
    e_ready = !reset && (mq.size() < DEPTH);
    e_mask  = 32'd0;
    foreach (mq[i]) e_mask = e_mask | (32'd1 << mq[i].addr);
    e_bypass = 1'b0;
`ifdef GRF_WB_BYPASS_EN
    e_bypass = !reset && !e_wact && (mq.size() == 0) && b_valid && (b_addr != 5'd0);
`endif
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
    if (!reset) begin
      if (e_wact) begin
        e_we = 1'b1; e_wa = w_addr; e_wd = w_data;
      end else if (mq.size() > 0) begin
        e_we = 1'b1; e_wa = mq[0].addr; e_wd = mq[0].data;
      end else if (e_bypass) begin
        e_we = 1'b1; e_wa = b_addr; e_wd = b_data;
      end
    end
  endtask

  task automatic model_update();
    wb_entry_t ent;
    logic popped;
    if (reset) begin
      mq.delete();
      m_streak = 0;
      m_stall  = 1'b0;
      m_waw    = 1'b0;
    end else begin
      popped = !e_wact && (mq.size() > 0);
      m_waw  = e_wact && e_mask[w_addr];
      if (popped || mq.size() == 0) m_streak = 0;
      else                          m_streak++;
      if (popped)                        m_stall = 1'b0;
      else if (m_streak >= STARVE_MAX)   m_stall = 1'b1;
      if (popped) void'(mq.pop_front());
      if (b_valid && e_ready && (b_addr != 5'd0) && !e_bypass) begin
        ent.addr = b_addr;
        ent.data = b_data;
        mq.push_back(ent);
      end
    end
  endtask

  // Drive one cycle's inputs, then compare every output against the model away from the clock edge.
  task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    reset = r; w_we = we; w_addr = wa; w_data = wd;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(negedge clk);
    model_comb();
    chk("m_grf_we", {31'd0, grf_we}, {31'd0, e_we});
    chk("m_grf_wa", {27'd0, grf_wa}, {27'd0, e_wa});
    chk("m_grf_wd", grf_wd, e_wd);
    chk("m_b_ready", {31'd0, b_ready}, {31'd0, e_ready});
    chk("m_pend_mask", pend_mask, e_mask);
    chk("m_stall_req", {31'd0, stall_req}, {31'd0, m_stall});
    chk("m_waw_err", {31'd0, waw_err}, {31'd0, m_waw});
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        rst, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        x_we;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
    logic        x_ready;
    logic [31:0] x_pend;
    logic        x_stall, x_waw;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic x_we, input logic [4:0] x_wa, input logic [31:0] x_wd,
                              input logic x_ready, input logic [31:0] x_pend, input logic x_stall,
                              input logic x_waw);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.bv = bv; v.ba = ba; v.bd = bd;
    v.x_we = x_we; v.x_wa = x_wa; v.x_wd = x_wd; v.x_ready = x_ready;
    v.x_pend = x_pend; v.x_stall = x_stall; v.x_waw = x_waw;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic seen;

    tbl[0]  = mk(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd2, 32'h22,       1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd2, 32'h22,       1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, REG_RA, 32'hFEED, 1'b0, 5'd0, 32'h0,    1'b1, REG_RA, 32'hFEED, 1'b1, 32'h0, 1'b0, 1'b0);
`ifdef GRF_WB_BYPASS_EN
    tbl[3]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hABCD,      1'b1, 5'd5, 32'hABCD, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
`else
    tbl[3]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hABCD,      1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 32'hABCD, 1'b1, 32'h20, 1'b0, 1'b0);
`endif
    tbl[5]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'h1234,   1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'h77,       1'b1, 5'd9, 32'h99, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h70, 1'b1, 32'h80, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 32'h77, 1'b1, 32'h80, 1'b0, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    reset = 1'b1; w_we = 1'b0; w_addr = 5'd0; w_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    adv();

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].bv, tbl[i].ba, tbl[i].bd);
      chk($sformatf("v%0d_grf_we", i), {31'd0, grf_we}, {31'd0, tbl[i].x_we});
      chk($sformatf("v%0d_grf_wa", i), {27'd0, grf_wa}, {27'd0, tbl[i].x_wa});
      chk($sformatf("v%0d_grf_wd", i), grf_wd, tbl[i].x_wd);
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].x_ready});
      chk($sformatf("v%0d_pend", i), pend_mask, tbl[i].x_pend);
      chk($sformatf("v%0d_stall", i), {31'd0, stall_req}, {31'd0, tbl[i].x_stall});
      chk($sformatf("v%0d_waw", i), {31'd0, waw_err}, {31'd0, tbl[i].x_waw});
      adv();
    end

    // Fill the queue behind a busy W stage, then drain it in order.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 5'd20, 32'h2000 + i, 1'b1, 5'(i), 32'hB000 + i);
      chk("fill_ready", {31'd0, b_ready}, 32'd1);
      adv();
    end
    cyc(1'b0, 1'b1, 5'd20, 32'h2005, 1'b1, 5'd5, 32'hB005);
    chk("full_ready", {31'd0, b_ready}, 32'd0);
    chk("full_pend", pend_mask, 32'h1E);
    adv();
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("drain_we", {31'd0, grf_we}, 32'd1);
      chk("drain_wa", {27'd0, grf_wa}, i);
      chk("drain_wd", grf_wd, 32'hB000 + i);
      adv();
    end
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("drained_we", {31'd0, grf_we}, 32'd0);
    adv();

    // Starvation: one queued entry behind continuous W writes.
    cyc(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd12, 32'hC12);
    adv();
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1'b0, 1'b1, 5'd9, 32'h900 + k, 1'b0, 5'd0, 32'h0);
      if (stall_req === 1'b1) seen = 1'b1;
      else                    waited++;
      adv();
    end
    chk("starve_seen", {31'd0, seen}, 32'd1);
    chk("starve_cycles", waited, STARVE_MAX);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("starve_pop_wa", {27'd0, grf_wa}, 32'd12);
    chk("starve_hold", {31'd0, stall_req}, 32'd1);
    adv();
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("starve_clear", {31'd0, stall_req}, 32'd0);
    adv();

    // Random traffic against the model; small address range provokes WAW and same-reg collisions.
    for (int n = 0; n < 1500; n++) begin
      logic        r, we, bv;
      logic [4:0]  wa, ba;
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 9) < 7);
      bv = ($urandom_range(0, 9) < 5);
      wa = ($urandom_range(0, 15) == 0) ? REG_RA : 5'($urandom_range(0, 7));
      ba = 5'($urandom_range(0, 7));
      cyc(r, we, wa, $urandom, bv, ba, $urandom);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
